// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with trap/redirect handling and a
//            circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter logic [31:0] TRAP_VECTOR  = 32'h100,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Stall,
    input  logic            i_Trap,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectPC,
    input  logic            i_Push,
    input  logic            i_Pop,
    output logic [XLEN-1:0] o_PC,
    output logic [XLEN-1:0] o_PrevPC,
    output logic            o_Flush,
    output logic            o_Misaligned,
    output logic            o_RasEmpty,
    output logic            o_RasOverflow,
    output logic            o_RasUnderflow
);

    localparam int c_PW = $clog2(RAS_DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_prev_pc;
    logic            r_flush;
    logic            r_misaligned;
    logic            r_overflow;
    logic            r_underflow;
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_ptr;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];

    logic [XLEN-1:0] w_seq_pc;
    logic [c_PW-1:0] w_top_idx;
    logic            w_empty;
    logic            w_full;
    logic            w_mis;
    logic            w_active;
    logic            w_push;
    logic            w_pop;

    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_prev_nxt;
    logic            w_flush_nxt;
    logic            w_mis_nxt;
    logic            w_ovf_nxt;
    logic            w_unf_nxt;
    logic [c_CW-1:0] w_count_nxt;
    logic [c_PW-1:0] w_ptr_nxt;
    logic            w_wr_en;
    logic [c_PW-1:0] w_wr_idx;

    assign w_seq_pc  = r_pc + XLEN'(4);
    assign w_top_idx = r_ptr - c_PW'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CW'(RAS_DEPTH));
    assign w_mis     = i_Redirect && (i_RedirectPC[1:0] != 2'b00);
    assign w_active  = !i_Stall && !i_Trap;
    assign w_push    = w_active && i_Push && !w_mis;
    assign w_pop     = w_active && i_Pop && !i_Redirect;

    always_comb begin
        w_pc_nxt    = r_pc;
        w_prev_nxt  = r_prev_pc;
        w_flush_nxt = 1'b0;
        w_mis_nxt   = 1'b0;
        w_ovf_nxt   = r_overflow;
        w_unf_nxt   = 1'b0;
        w_count_nxt = r_count;
        w_ptr_nxt   = r_ptr;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_ptr;

        if (i_Trap) begin
            w_pc_nxt    = XLEN'(TRAP_VECTOR);
            w_prev_nxt  = r_pc;
            w_flush_nxt = 1'b1;
        end else if (!i_Stall) begin
            w_prev_nxt = r_pc;
            if (i_Redirect) begin
                w_flush_nxt = 1'b1;
                w_mis_nxt   = w_mis;
                w_pc_nxt    = w_mis ? XLEN'(TRAP_VECTOR) : i_RedirectPC;
            end else if (w_pop && !w_empty) begin
                w_pc_nxt    = r_ras[w_top_idx];
                w_flush_nxt = 1'b1;
            end else begin
                w_pc_nxt  = w_seq_pc;
                w_unf_nxt = w_pop;
            end

            // A push paired with a successful pop rewrites the top in place
            if (w_pop && !w_empty) begin
                if (w_push) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_top_idx;
                end else begin
                    w_ptr_nxt   = w_top_idx;
                    w_count_nxt = r_count - c_CW'(1);
                end
            end else if (w_push) begin
                w_wr_en   = 1'b1;
                w_ptr_nxt = r_ptr + c_PW'(1);
                if (w_full) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_pc         <= XLEN'(RESET_VECTOR);
            r_prev_pc    <= '0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_count      <= '0;
            r_ptr        <= '0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_prev_pc    <= w_prev_nxt;
            r_flush      <= w_flush_nxt;
            r_misaligned <= w_mis_nxt;
            r_overflow   <= w_ovf_nxt;
            r_underflow  <= w_unf_nxt;
            r_count      <= w_count_nxt;
            r_ptr        <= w_ptr_nxt;
        end
    end

    // Entry storage carries no reset; contents are invisible while empty
    always_ff @(posedge i_Clk) begin
        if (!i_Rst && w_wr_en) begin
            r_ras[w_wr_idx] <= w_seq_pc;
        end
    end

    assign o_PC           = r_pc;
    assign o_PrevPC       = r_prev_pc;
    assign o_Flush        = r_flush;
    assign o_Misaligned   = r_misaligned;
    assign o_RasEmpty     = w_empty;
    assign o_RasOverflow  = r_overflow;
    assign o_RasUnderflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed vector bench for pc_sequencer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall, trap, redir, push, pop;
    logic [31:0] rpc;
    logic [31:0] pc, prev;
    logic        flush, mis, empty, ovf, unf;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst, stall, trap, redir, push, pop;
        logic [31:0] rpc;
        logic [31:0] pc, prev;
        logic        flush, mis, empty, ovf, unf;
    } vec_t;

    vec_t tbl[$];

    pc_sequencer dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Stall       (stall),
        .i_Trap        (trap),
        .i_Redirect    (redir),
        .i_RedirectPC  (rpc),
        .i_Push        (push),
        .i_Pop         (pop),
        .o_PC          (pc),
        .o_PrevPC      (prev),
        .o_Flush       (flush),
        .o_Misaligned  (mis),
        .o_RasEmpty    (empty),
        .o_RasOverflow (ovf),
        .o_RasUnderflow(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, s, t, d, input logic [31:0] a,
                       input logic pu, po, input logic [31:0] epc, eprev,
                       input logic ef, em, ee, eo, eu);
        vec_t v;
        v.rst = r; v.stall = s; v.trap = t; v.redir = d; v.rpc = a;
        v.push = pu; v.pop = po; v.pc = epc; v.prev = eprev;
        v.flush = ef; v.mis = em; v.empty = ee; v.ovf = eo; v.unf = eu;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; stall = v.stall; trap = v.trap; redir = v.redir;
        rpc = v.rpc; push = v.push; pop = v.pop;
        @(posedge clk);
        #1;
        n_vec++;
        if (pc !== v.pc || prev !== v.prev || flush !== v.flush ||
            mis !== v.mis || empty !== v.empty || ovf !== v.ovf || unf !== v.unf) begin
            n_err++;
            $display("FAIL %s: got pc=%h prev=%h fl=%b mis=%b emp=%b ovf=%b unf=%b, want pc=%h prev=%h fl=%b mis=%b emp=%b ovf=%b unf=%b",
                     name, pc, prev, flush, mis, empty, ovf, unf,
                     v.pc, v.prev, v.flush, v.mis, v.empty, v.ovf, v.unf);
        end
    endtask

    initial begin
        vec_t h;
        n_vec = 0; n_err = 0;
        rst = 1'b1; stall = 1'b0; trap = 1'b0; redir = 1'b0;
        rpc = '0; push = 1'b0; pop = 1'b0;

        //   rst s t d  rpc          pu po  pc            prev          f m e o u
        add(1, 0,0,0, 32'h0,        0,0,  32'h0,        32'h0,        0,0,1,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'h4,        32'h0,        0,0,1,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'h8,        32'h4,        0,0,1,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'hC,        32'h8,        0,0,1,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'h10,       32'hC,        0,0,1,0,0);
        // call / return
        add(0, 0,0,1, 32'h200,      1,0,  32'h200,      32'h10,       1,0,0,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'h204,      32'h200,      0,0,0,0,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h14,       32'h204,      1,0,1,0,0);
        // misaligned, trap during stall, plain stall
        add(0, 0,0,1, 32'h202,      0,0,  32'h100,      32'h14,       1,1,1,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'h104,      32'h100,      0,0,1,0,0);
        add(0, 1,1,0, 32'h0,        0,0,  32'h100,      32'h104,      1,0,1,0,0);
        add(0, 1,0,1, 32'h300,      1,1,  32'h100,      32'h104,      0,0,1,0,0);
        // five calls overflow a 4-deep stack
        add(0, 0,0,1, 32'h1000,     1,0,  32'h1000,     32'h100,      1,0,0,0,0);
        add(0, 0,0,1, 32'h2000,     1,0,  32'h2000,     32'h1000,     1,0,0,0,0);
        add(0, 0,0,1, 32'h3000,     1,0,  32'h3000,     32'h2000,     1,0,0,0,0);
        add(0, 0,0,1, 32'h4000,     1,0,  32'h4000,     32'h3000,     1,0,0,0,0);
        add(0, 0,0,1, 32'h5000,     1,0,  32'h5000,     32'h4000,     1,0,0,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h4004,     32'h5000,     1,0,0,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h3004,     32'h4004,     1,0,0,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h2004,     32'h3004,     1,0,0,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h1004,     32'h2004,     1,0,1,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h1008,     32'h1004,     0,0,1,1,1);
        add(0, 0,0,0, 32'h0,        0,0,  32'h100C,     32'h1008,     0,0,1,1,0);
        // redirect beats pop; entry survives
        add(0, 0,0,0, 32'h0,        1,0,  32'h1010,     32'h100C,     0,0,0,1,0);
        add(0, 0,0,1, 32'h800,      0,1,  32'h800,      32'h1010,     1,0,0,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h1010,     32'h800,      1,0,1,1,0);
        // push+pop replaces top; push+pop on empty
        add(0, 0,0,0, 32'h0,        1,0,  32'h1014,     32'h1010,     0,0,0,1,0);
        add(0, 0,0,0, 32'h0,        1,1,  32'h1014,     32'h1014,     1,0,0,1,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h1018,     32'h1014,     1,0,1,1,0);
        add(0, 0,0,0, 32'h0,        1,1,  32'h101C,     32'h1018,     0,0,0,1,1);
        add(0, 0,0,0, 32'h0,        0,1,  32'h101C,     32'h101C,     1,0,1,1,0);
        // reset during stall
        add(0, 1,0,0, 32'h0,        0,0,  32'h101C,     32'h101C,     0,0,1,1,0);
        add(1, 1,0,0, 32'h0,        0,0,  32'h0,        32'h0,        0,0,1,0,0);
        // trap ignores push/pop; misaligned ignores push
        add(0, 0,0,0, 32'h0,        0,0,  32'h4,        32'h0,        0,0,1,0,0);
        add(0, 0,1,0, 32'h0,        1,1,  32'h100,      32'h4,        1,0,1,0,0);
        add(0, 0,0,0, 32'h0,        0,1,  32'h104,      32'h100,      0,0,1,0,1);
        add(0, 0,0,1, 32'h203,      1,0,  32'h100,      32'h104,      1,1,1,0,0);
        // wrap at top of address space
        add(0, 0,0,1, 32'hFFFFFFFC, 0,0,  32'hFFFFFFFC, 32'h100,      1,0,1,0,0);
        add(0, 0,0,0, 32'h0,        0,0,  32'h0,        32'hFFFFFFFC, 0,0,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: reset wins over a trap in the same cycle
        h.rst = 0; h.stall = 0; h.trap = 1; h.redir = 0; h.rpc = '0;
        h.push = 0; h.pop = 0;
        h.pc = 32'h100; h.prev = 32'h0; h.flush = 1; h.mis = 0;
        h.empty = 1; h.ovf = 0; h.unf = 0;
        apply(h, "trap_before_rst");
        h.rst = 1; h.pc = 32'h0; h.prev = 32'h0; h.flush = 0;
        apply(h, "rst_mid_trap");
        h.rst = 0; h.trap = 0; h.pc = 32'h4; h.prev = 32'h0;
        apply(h, "after_rst_seq");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL provide these parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 0, PC value after reset.
- TRAP_VECTOR, 32'h100, PC value on trap or misaligned redirect.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2).

REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- i_Clk  in  1  clock.
- i_Rst  in  1  reset, synchronous, active-high.
- i_Stall  in  1  hold PC and RAS.
- i_Trap  in  1  force PC to TRAP_VECTOR.
- i_Redirect  in  1  branch/jump taken.
- i_RedirectPC  in  XLEN  redirect target.
- i_Push  in  1  call: push PC+4 onto RAS.
- i_Pop  in  1  return: next PC = RAS top.
- o_PC  out  XLEN  current PC.
- o_PrevPC  out  XLEN  PC before last update.
- o_Flush  out  1  one-cycle pulse after a non-sequential PC update.
- o_Misaligned  out  1  one-cycle pulse after a misaligned redirect.
- o_RasEmpty  out  1  RAS holds no entries.
- o_RasOverflow  out  1  sticky: a push occurred while the RAS was full.
- o_RasUnderflow  out  1  one-cycle pulse after a pop on an empty RAS.

Function
REQ-003 All state SHALL update only on the rising edge of i_Clk.

REQ-004 Next-PC priority SHALL be, highest first: i_Rst, i_Trap, i_Stall, i_Redirect, i_Pop, sequential.

REQ-005 i_Trap SHALL set o_PC to TRAP_VECTOR even while i_Stall=1; i_Push and i_Pop SHALL be ignored that cycle, and o_Flush SHALL pulse.

REQ-006 With i_Stall=1 and i_Trap=0:
- o_PC, o_PrevPC and the RAS SHALL hold.
- All pulse outputs SHALL be 0.

REQ-007 On redirect with i_RedirectPC[1:0]=0, o_PC SHALL become i_RedirectPC and o_Flush SHALL pulse.

REQ-008 On redirect with i_RedirectPC[1:0]≠0:
- o_PC SHALL become TRAP_VECTOR.
- o_Misaligned and o_Flush SHALL pulse.
- The RAS SHALL be unchanged.

REQ-009 On pop (no redirect) with the RAS non-empty:
- o_PC SHALL become the top entry.
- The entry count SHALL decrement.
- o_Flush SHALL pulse.

REQ-010 On pop with the RAS empty:
- o_PC SHALL advance sequentially.
- o_RasUnderflow SHALL pulse.
- o_Flush SHALL stay 0.

REQ-011 When no other case applies, o_PC SHALL become o_PC+4, wrapping modulo 2^XLEN.

REQ-012 i_Push (not stalled, no trap, no misaligned redirect) SHALL push o_PC+4, whether the PC update is a redirect (call) or sequential.

REQ-013 On push while the RAS is full:
- The oldest entry SHALL be overwritten (circular buffer).
- The count SHALL stay RAS_DEPTH.
- o_RasOverflow SHALL set and stay set until reset.

REQ-014 i_Redirect together with i_Pop SHALL take the redirect; the pop SHALL be ignored and the RAS unchanged.

REQ-015 i_Push together with i_Pop (no redirect) SHALL:
- set o_PC to the old top entry;
- replace the top entry with o_PC+4;
- leave the count unchanged.
If the RAS is empty, this SHALL behave as a push plus REQ-010.

REQ-016 Whenever o_PC updates, o_PrevPC SHALL take the old o_PC value in the same edge.

REQ-017 o_RasEmpty SHALL be 1 exactly when the entry count is 0.

Reset
REQ-018 When i_Rst=1 at a clock edge:
- o_PC SHALL become RESET_VECTOR; o_PrevPC SHALL become 0.
- The RAS count and pointer SHALL become 0.
- o_RasEmpty SHALL become 1.
- All pulse outputs and o_RasOverflow SHALL become 0.
This SHALL override all other inputs, including mid-stall and mid-trap.

REQ-019 RAS entry contents SHALL need no reset; they are unobservable while the count is 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios (default parameters):
- Reset then 3 idle cycles -> o_PC = 0, 4, 8, 12; o_PrevPC = 8 on the last; o_RasEmpty=1.
- At PC=0x10: i_Push+i_Redirect to 0x200, then i_Pop at 0x204 -> o_PC = 0x200, 0x204, 0x14; o_Flush pulses twice; o_RasEmpty=1 at end.
- Redirect to 0x202 -> o_PC=0x100, o_Misaligned=1 for one cycle; i_Stall+i_Trap -> o_PC=0x100, o_PrevPC=old PC.
- 5 consecutive push-calls, then 5 pops -> o_RasOverflow=1 after the 5th push; pops return the last 4 addresses in LIFO order; the 5th pop advances sequentially with o_RasUnderflow=1.
- i_Redirect+i_Pop with 1 entry -> o_PC = target, count stays 1; i_Rst during i_Stall -> o_PC=0 next edge.
- XLEN=32 at PC=0xFFFFFFFC, sequential -> o_PC=0, o_PrevPC=0xFFFFFFFC.
